// File: rtl/demux_stream_router_1x4_if.sv
// Stream bundle between one producer, the 1x4 router and four consumers.
// The slave modport is the router's view; master is the producer/consumer side.
interface demux_stream_router_1x4_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [1:0]           in_sel;
    logic                 auto_mode;
    logic                 cnt_clr;
    logic [3:0]           y_valid;
    logic [3:0]           y_ready;
    logic [4*WIDTH-1:0]   y_data;
    logic [1:0]           rr_ptr;
    logic [4*CNT_W-1:0]   beat_cnt;

    modport slave (
        input  in_valid, in_data, in_sel, auto_mode, cnt_clr, y_ready,
        output in_ready, y_valid, y_data, rr_ptr, beat_cnt
    );

    modport master (
        output in_valid, in_data, in_sel, auto_mode, cnt_clr, y_ready,
        input  in_ready, y_valid, y_data, rr_ptr, beat_cnt
    );
endinterface

// File: rtl/demux_stream_router_1x4.sv
// Routes one valid/ready stream to four registered output channels, chosen by
// an explicit select or a round-robin pointer, with per-channel beat counters.
module demux_stream_router_1x4 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    demux_stream_router_1x4_if.slave  bus
);

    logic [3:0]       ch_valid;
    logic [WIDTH-1:0] ch_data [4];
    logic [CNT_W-1:0] cnt     [4];
    logic [1:0]       rr_ptr_q;

    logic [1:0]       dest;
    logic             in_ready;
    logic             accept;

    // in_ready deliberately has no path from in_valid, so a producer may
    // wait for ready before raising valid without a combinational loop.
    always_comb begin
        dest     = bus.auto_mode ? rr_ptr_q : bus.in_sel;
        in_ready = !ch_valid[dest] | bus.y_ready[dest];
        accept   = bus.in_valid & in_ready;
    end

    // NOTE: every register below uses <= so all channels, the pointer and the
    // counters update from the same pre-edge values; the payload registers are
    // reset too because y_data must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_valid <= '0;
            for (int i = 0; i < 4; i++) ch_data[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (accept && dest == 2'(i)) begin
                    ch_valid[i] <= 1'b1;
                    ch_data[i]  <= bus.in_data;
                end else if (ch_valid[i] && bus.y_ready[i]) begin
                    ch_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else if (accept && bus.auto_mode) begin
            rr_ptr_q <= rr_ptr_q + 2'd1;
        end
    end

    // Clear wins over a same-cycle increment; the beat itself is still routed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (bus.cnt_clr) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (accept) begin
            cnt[dest] <= cnt[dest] + CNT_W'(1);
        end
    end

    always_comb begin
        bus.in_ready = in_ready;
        bus.y_valid  = ch_valid;
        bus.rr_ptr   = rr_ptr_q;
        bus.y_data   = '0;
        bus.beat_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            bus.y_data[i*WIDTH +: WIDTH]   = ch_data[i];
            bus.beat_cnt[i*CNT_W +: CNT_W] = cnt[i];
        end
    end

endmodule
